// File: rtl/dpwm_generador.sv
// rtl/dpwm_generador.sv - glitch-free DPWM with power-of-two periods and boundary-latched settings
module dpwm_generador #(
    parameter int BASE_LOG2 = 11,
    parameter int DUTY_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [2:0]        numero_frec,
    input  logic [DUTY_W-1:0] ciclo_trabajo,
    output logic              pwm_out,
    output logic              fin_periodo,
    output logic [2:0]        frec_activa
);

    localparam int CW = BASE_LOG2 + 1;
    localparam int PW = CW + DUTY_W;

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state, state_n;
    logic [BASE_LOG2-1:0] cuenta, cuenta_n;
    logic [2:0]           frec_sh, frec_n;
    logic [DUTY_W-1:0]    duty_sh, duty_n;
    logic                 pwm_n, fin_n;

    function automatic logic [CW-1:0] period_of(input logic [2:0] k);
        period_of = CW'(1) << (BASE_LOG2 - int'(k));
    endfunction

    function automatic logic [BASE_LOG2-1:0] last_of(input logic [2:0] k);
        last_of = BASE_LOG2'(period_of(k) - CW'(1));
    endfunction

    // duty * P / 2^DUTY_W, done at full width so every selection shares one formula
    function automatic logic [CW-1:0] umbral_of(input logic [2:0] k, input logic [DUTY_W-1:0] d);
        logic [PW-1:0] prod;
        prod      = PW'(d) * PW'(period_of(k));
        umbral_of = CW'(prod >> DUTY_W);
    endfunction

    always_comb begin
        state_n  = state;
        cuenta_n = cuenta;
        frec_n   = frec_sh;
        duty_n   = duty_sh;
        case (state)
            IDLE: begin
                cuenta_n = '0;
                if (enable) begin
                    state_n = RUN;
                    frec_n  = numero_frec;
                    duty_n  = ciclo_trabajo;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_n  = IDLE;
                    cuenta_n = '0;
                end else if (cuenta == last_of(frec_sh)) begin
                    cuenta_n = '0;
                    frec_n   = numero_frec;
                    duty_n   = ciclo_trabajo;
                end else begin
                    cuenta_n = cuenta + BASE_LOG2'(1);
                end
            end
            default: state_n = IDLE;
        endcase
        // Outputs are registered from next-state values so they align with cuenta without extra latency
        pwm_n = (state_n == RUN) && (CW'(cuenta_n) < umbral_of(frec_n, duty_n));
        fin_n = (state_n == RUN) && (cuenta_n == last_of(frec_n));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cuenta      <= '0;
            frec_sh     <= '0;
            duty_sh     <= '0;
            pwm_out     <= 1'b0;
            fin_periodo <= 1'b0;
        end else begin
            state       <= state_n;
            cuenta      <= cuenta_n;
            frec_sh     <= frec_n;
            duty_sh     <= duty_n;
            pwm_out     <= pwm_n;
            fin_periodo <= fin_n;
        end
    end

    assign frec_activa = frec_sh;

endmodule

// File: tb/tb_dpwm_generador.sv
// tb/tb_dpwm_generador.sv - directed and randomized checks of dpwm_generador against a cycle model
module tb_dpwm_generador;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [2:0] numero_frec;
    logic [7:0] ciclo_trabajo;
    logic       pwm_out;
    logic       fin_periodo;
    logic [2:0] frec_activa;

    int passes = 0;
    int total  = 0;

    bit m_run;
    int m_cnt, m_k, m_duty;

    dpwm_generador #(.BASE_LOG2(11), .DUTY_W(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .numero_frec   (numero_frec),
        .ciclo_trabajo (ciclo_trabajo),
        .pwm_out       (pwm_out),
        .fin_periodo   (fin_periodo),
        .frec_activa   (frec_activa)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int per(input int k);
        return 2048 >> k;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) begin
            m_run = 0; m_cnt = 0; m_k = 0; m_duty = 0;
        end else if (!m_run) begin
            if (enable) begin
                m_run = 1; m_cnt = 0; m_k = int'(numero_frec); m_duty = int'(ciclo_trabajo);
            end
        end else if (!enable) begin
            m_run = 0; m_cnt = 0;
        end else if (m_cnt == per(m_k) - 1) begin
            m_cnt = 0; m_k = int'(numero_frec); m_duty = int'(ciclo_trabajo);
        end else begin
            m_cnt++;
        end
        #1;
        check("pwm_out", 32'(pwm_out), 32'(m_run && (m_cnt < (m_duty * per(m_k)) / 256)));
        check("fin_periodo", 32'(fin_periodo), 32'(m_run && (m_cnt == per(m_k) - 1)));
        check("frec_activa", 32'(frec_activa), 32'(m_k));
    endtask

    // Waits for the current period to end, then measures the following full period
    task automatic measure_period(output int len, output int highs);
        int b;
        b = 0;
        while (fin_periodo !== 1'b1 && b < 5000) begin
            step();
            b++;
        end
        check("wait_fin", 32'(fin_periodo), 32'd1);
        len   = 0;
        highs = 0;
        do begin
            step();
            len++;
            highs += int'(pwm_out);
        end while (fin_periodo !== 1'b1 && len < 5000);
    endtask

    initial begin
        int len, highs, b;
        reset = 1'b1; enable = 1'b0; numero_frec = 3'd0; ciclo_trabajo = 8'd0;
        step();
        step();
        check("reset_pwm", 32'(pwm_out), 32'd0);
        reset = 1'b0;
        step();

        enable = 1'b1; numero_frec = 3'd7; ciclo_trabajo = 8'd128;
        step();
        check("t1_first_pwm", 32'(pwm_out), 32'd1);
        highs = int'(pwm_out);
        len = 0;
        for (int i = 0; i < 31; i++) begin
            step();
            highs += int'(pwm_out);
            len += int'(fin_periodo);
        end
        check("t1_highs_2per", 32'(highs), 32'd16);
        check("t1_fins_2per", 32'(len), 32'd2);
        check("t1_frec", 32'(frec_activa), 32'd7);

        ciclo_trabajo = 8'd0;
        measure_period(len, highs);
        check("t2_d0_len", 32'(len), 32'd16);
        check("t2_d0_highs", 32'(highs), 32'd0);
        ciclo_trabajo = 8'd255;
        measure_period(len, highs);
        check("t2_d255_len", 32'(len), 32'd16);
        check("t2_d255_highs", 32'(highs), 32'd15);

        ciclo_trabajo = 8'd128;
        measure_period(len, highs);
        b = 0;
        while (m_cnt != 5 && b < 100) begin
            step();
            b++;
        end
        numero_frec = 3'd6;
        measure_period(len, highs);
        check("t3_len", 32'(len), 32'd32);
        check("t3_highs", 32'(highs), 32'd16);
        check("t3_frec", 32'(frec_activa), 32'd6);

        numero_frec = 3'd7;
        measure_period(len, highs);
        b = 0;
        while (m_cnt != 3 && b < 100) begin
            step();
            b++;
        end
        check("t4_pwm_before", 32'(pwm_out), 32'd1);
        enable = 1'b0;
        step();
        check("t4_pwm_off", 32'(pwm_out), 32'd0);
        step();
        enable = 1'b1;
        step();
        check("t4_restart_pwm", 32'(pwm_out), 32'd1);
        len = 1;
        while (fin_periodo !== 1'b1 && len < 100) begin
            step();
            len++;
        end
        check("t4_restart_len", 32'(len), 32'd16);

        step(); step(); step();
        reset = 1'b1;
        step();
        check("t5_pwm", 32'(pwm_out), 32'd0);
        check("t5_fin", 32'(fin_periodo), 32'd0);
        check("t5_frec", 32'(frec_activa), 32'd0);
        reset = 1'b0;
        step();
        check("t5_resume", 32'(pwm_out), 32'd1);

        numero_frec = 3'd0; ciclo_trabajo = 8'd64;
        measure_period(len, highs);
        check("t6_len", 32'(len), 32'd2048);
        check("t6_highs", 32'(highs), 32'd512);

        numero_frec = 3'd5;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) numero_frec = 3'($urandom_range(4, 7));
            if ($urandom_range(0, 7) == 0) ciclo_trabajo = 8'($urandom_range(0, 255));
            enable = ($urandom_range(0, 29) != 0);
            reset  = ($urandom_range(0, 79) == 0);
            step();
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/dpwm_generador.md
# dpwm_generador

Digital PWM generator that converts the 3-bit frequency selection `numero_frec` from the button-driven programmable frequency counter into a square-wave drive signal. The block runs from the system clock. It derives one of eight power-of-two switching periods and applies an 8-bit duty-cycle command. New frequency and duty values are only adopted at period boundaries, so the output never glitches. It sits directly downstream of the frequency counter and drives the converter's switch or the board output pin.

## Interface
- `BASE_LOG2`, default 11: log2 of the longest period in clock cycles (selection 0 = 2048 cycles).
- `DUTY_W`, default 8: duty-command width; the spec values below assume 8.
- `clk` input 1: system clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `enable` input 1: level; 1 = generate PWM, 0 = output held low.
- `numero_frec` input 3: frequency select from the upstream counter; higher value = higher frequency.
- `ciclo_trabajo` input DUTY_W: duty command, 0..255.
- `pwm_out` output 1: PWM drive, registered.
- `fin_periodo` output 1: one-cycle pulse on the last cycle of each period.
- `frec_activa` output 3: frequency selection currently in effect (shadow register).

## Operation
- Period for shadow selection k: P(k) = 2^(BASE_LOG2 − k), giving 2048, 1024, 512, 256, 128, 64, 32, 16 cycles for k = 0..7.
- Threshold: umbral = (duty_sh × P(k)) >> 8, equivalently duty_sh << (BASE_LOG2 − 8 − k). For k = 7 this is duty_sh >> 4.
- Counter `cuenta` has width BASE_LOG2, counts 0..P(k)−1, then wraps to 0.
- `pwm_out` = 1 exactly in the cycles where cuenta < umbral, else 0.
- Duty 0 gives a constant 0.
- Duty 255 gives P − P/256 high cycles. This is 2040 of 2048 at k = 0 and 15 of 16 at k = 7. 100 % is never produced.
- FSM states:
  - IDLE: cuenta = 0, pwm_out = 0, fin_periodo = 0. If enable = 1 at an edge, load frec_sh ← numero_frec and duty_sh ← ciclo_trabajo, set cuenta = 0, and go to RUN.
  - RUN: cuenta increments every cycle. In the cycle where cuenta = P(k)−1, fin_periodo = 1. At the following edge, cuenta ← 0 and the shadow registers reload from the inputs.
  - RUN with enable = 0 at an edge: go to IDLE. The current period is aborted and the shadow registers are kept.
- Input changes mid-period have no effect until the next boundary. Only the values present at the boundary edge are taken; intermediate changes are lost.
- A change of numero_frec across the boundary changes both P and umbral for the new period.
- `frec_activa` = frec_sh.

## Timing
- Reset values, at the edge where reset = 1: state IDLE, cuenta = 0, frec_sh = 0, duty_sh = 0, pwm_out = 0, fin_periodo = 0, frec_activa = 0.
- Reset overrides enable and takes effect mid-period.
- Enable sampled 1 at edge t gives the first RUN cycle t+1 with cuenta = 0.
  - In that cycle pwm_out is already (0 < umbral) of the newly loaded values, i.e. 1 if duty ≠ 0.
  - pwm_out is loaded at the same edge from the next-state cuenta and shadow values. There is no extra pipeline cycle.
- Enable sampled 0 in RUN at edge t: pwm_out = 0 and fin_periodo = 0 from cycle t+1 onward.
- fin_periodo is high for exactly 1 cycle per period. In steady state it fires every P(k) cycles.
- Reconfiguration latency: a new input value takes effect at most P(k) cycles after it is applied, at the first boundary.
- pwm_out, fin_periodo and frec_activa are all flop outputs, with no combinational path from inputs.

## Test plan
1. Reset, then enable = 1, numero_frec = 7, ciclo_trabajo = 128 → period 16. pwm_out is high for 8 cycles then low for 8. fin_periodo pulses every 16 cycles. frec_activa = 7.
2. numero_frec = 7: ciclo_trabajo = 0 → pwm_out constantly 0. Then ciclo_trabajo = 255 → after the next boundary, 15 high and 1 low per period.
3. Running at frec 7, duty 128, change numero_frec to 6 at cuenta = 5 → the current period still completes 16 cycles. The next period is 32 cycles with 16 high. frec_activa changes 7→6 at the boundary edge.
4. Drop enable at cuenta = 3 while pwm_out = 1 → pwm_out = 0 on the next cycle. Re-enable → the restart has cuenta = 0, pwm_out = 1 in the first cycle, and a full-length period.
5. Assert reset for 1 cycle mid-RUN with enable held at 1 → all outputs 0 and frec_activa = 0 in the next cycle. RUN resumes one cycle after reset deasserts.
6. numero_frec = 0, ciclo_trabajo = 64 → 512 high and 1536 low cycles per 2048-cycle period. fin_periodo is asserted only when cuenta = 2047.
